// File: rtl/adc_if.sv
// Sample bus from the I2S ADC receiver to its consumer (FIFO or CPU register).
// The receiver drives it through the master modport; the consumer reads through slave.
interface adc_if #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] sample_l;
   logic [DATA_WIDTH-1:0] sample_r;
   logic                  ready;

   modport master (output sample_l, output sample_r, output ready);
   modport slave  (input  sample_l, input  sample_r, input  ready);
endinterface

// File: rtl/adc.sv
// I2S stereo ADC receiver: builds mclk/bclk/lrck from a 10-bit timebase and
// deserializes sdto into left/right samples, strobing ready once per frame.
module adc #(
   parameter int DATA_WIDTH = 24
) (
   input  logic  clk,
   input  logic  rst,
   adc_if.master bus,
   output logic  mclk,
   output logic  bclk,
   output logic  lrck,
   input  logic  sdto
);
   localparam logic [4:0] LAST_SLOT = 5'(DATA_WIDTH);

   logic [9:0]            cnt;
   logic                  sd_s1;
   logic                  sd_s2;
   logic [DATA_WIDTH-1:0] shift;
   logic [DATA_WIDTH-1:0] hold_l;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic [4:0]            slot;
   logic                  sample_pt;
   logic                  data_slot;

   // Codec clocks come straight from counter flops, so they cannot glitch.
   always_comb begin
      mclk      = cnt[1];
      bclk      = cnt[3];
      lrck      = cnt[9];
      slot      = cnt[8:4];
      sample_pt = (cnt[3:0] == 4'hB);
      data_slot = (slot != '0) && (slot <= LAST_SLOT);
      shift_nxt = {shift[DATA_WIDTH-2:0], sd_s2};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         sd_s1        <= 1'b0;
         sd_s2        <= 1'b0;
         shift        <= '0;
         hold_l       <= '0;
         bus.sample_l <= '0;
         bus.sample_r <= '0;
         bus.ready    <= 1'b0;
      end else begin
         cnt       <= cnt + 10'd1;
         sd_s1     <= sdto;
         sd_s2     <= sd_s1;
         bus.ready <= 1'b0;
         if (sample_pt && data_slot) begin
            shift <= shift_nxt;
            // Left word is parked until the right word completes so the pair
            // published to the consumer always comes from one frame.
            if (slot == LAST_SLOT) begin
               if (!cnt[9]) begin
                  hold_l <= shift_nxt;
               end else begin
                  bus.sample_l <= hold_l;
                  bus.sample_r <= shift_nxt;
                  bus.ready    <= 1'b1;
               end
            end
         end
      end
   end
endmodule
